// File: rtl/conv3x3_controller.sv
// 3x3 zero-padded convolution engine: reads a source image SRAM, writes a destination SRAM.
// Define CONV_SATURATE_EN to clamp results to 0..255; otherwise the low 8 bits are kept.

typedef struct packed {
    logic        re;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
} img_sram_ctrl_t;

module conv3x3_controller #(
    parameter int ACC_W = 21
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           en,
    input  logic [7:0]     nrows,
    input  logic [7:0]     ncols,
    input  logic [71:0]    kernel,
    input  logic [3:0]     shift,
    output logic           busy,
    output img_sram_ctrl_t src_sram_ctrl,
    input  logic [7:0]     src_sram_dout_in,
    output img_sram_ctrl_t dst_sram_ctrl
);

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StWrite} state_e;

    state_e                  state_q, state_d;
    logic [7:0]              nrows_q, nrows_d;
    logic [7:0]              ncols_q, ncols_d;
    logic [71:0]             kernel_q, kernel_d;
    logic [3:0]              shift_q, shift_d;
    logic [7:0]              row_q, row_d;
    logic [7:0]              col_q, col_d;
    logic [1:0]              tr_q, tr_d;
    logic [1:0]              tc_q, tc_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    pend_q, pend_d;
    logic [7:0]              coef_q, coef_d;

    logic [3:0]              tap_idx;
    logic [71:0]             kernel_sh;
    logic                    row_ok, col_ok, tap_ok;
    logic [7:0]              src_row, src_col;
    logic signed [16:0]      pix_s, coef_s, prod;
    logic signed [ACC_W-1:0] acc_sum, shifted;
    logic [7:0]              result;

    // Tap geometry: tr/tc are dr+1/dc+1 of the current tap.
    always_comb begin
        tap_idx   = {2'b00, tr_q} * 4'd3 + {2'b00, tc_q};
        kernel_sh = kernel_q >> {tap_idx, 3'b000};
        row_ok    = (tr_q == 2'd0) ? (row_q != 8'd0) :
                    (tr_q == 2'd1) ? 1'b1 : (({1'b0, row_q} + 9'd1) < {1'b0, nrows_q});
        col_ok    = (tc_q == 2'd0) ? (col_q != 8'd0) :
                    (tc_q == 2'd1) ? 1'b1 : (({1'b0, col_q} + 9'd1) < {1'b0, ncols_q});
        tap_ok    = row_ok && col_ok;
        src_row   = row_q + {6'b0, tr_q} - 8'd1;
        src_col   = col_q + {6'b0, tc_q} - 8'd1;
    end

    // Data for the tap requested last cycle arrives now.
    always_comb begin
        pix_s   = $signed({9'b0, src_sram_dout_in});
        coef_s  = $signed({{9{coef_q[7]}}, coef_q});
        prod    = pix_s * coef_s;
        acc_sum = pend_q ? (acc_q + {{(ACC_W-17){prod[16]}}, prod}) : acc_q;
        shifted = acc_q >>> shift_q;
`ifdef CONV_SATURATE_EN
        if (shifted[ACC_W-1]) begin
            result = 8'd0;
        end else if (|shifted[ACC_W-2:8]) begin
            result = 8'd255;
        end else begin
            result = shifted[7:0];
        end
`else
        result = shifted[7:0];
`endif
    end

    always_comb begin
        state_d       = state_q;
        nrows_d       = nrows_q;
        ncols_d       = ncols_q;
        kernel_d      = kernel_q;
        shift_d       = shift_q;
        row_d         = row_q;
        col_d         = col_q;
        tr_d          = tr_q;
        tc_d          = tc_q;
        acc_d         = acc_q;
        pend_d        = 1'b0;
        coef_d        = coef_q;
        src_sram_ctrl = '0;
        dst_sram_ctrl = '0;

        unique case (state_q)
            StIdle: begin
                if (en && (nrows != 8'd0) && (ncols != 8'd0)) begin
                    nrows_d  = nrows;
                    ncols_d  = ncols;
                    kernel_d = kernel;
                    shift_d  = shift;
                    row_d    = 8'd0;
                    col_d    = 8'd0;
                    tr_d     = 2'd0;
                    tc_d     = 2'd0;
                    acc_d    = '0;
                    state_d  = StRead;
                end
            end
            StRead: begin
                acc_d  = ((tr_q == 2'd0) && (tc_q == 2'd0)) ? '0 : acc_sum;
                pend_d = tap_ok;
                coef_d = kernel_sh[7:0];
                if (tap_ok) begin
                    src_sram_ctrl.re   = 1'b1;
                    src_sram_ctrl.addr = {8'b0, src_row} * {8'b0, ncols_q} + {8'b0, src_col};
                end
                if (tc_q == 2'd2) begin
                    tc_d = 2'd0;
                    if (tr_q == 2'd2) begin
                        tr_d    = 2'd0;
                        state_d = StDrain;
                    end else begin
                        tr_d = tr_q + 2'd1;
                    end
                end else begin
                    tc_d = tc_q + 2'd1;
                end
            end
            StDrain: begin
                acc_d   = acc_sum;
                state_d = StWrite;
            end
            StWrite: begin
                dst_sram_ctrl.we    = 1'b1;
                dst_sram_ctrl.addr  = {8'b0, row_q} * {8'b0, ncols_q} + {8'b0, col_q};
                dst_sram_ctrl.wdata = result;
                state_d             = StRead;
                if (col_q == ncols_q - 8'd1) begin
                    col_d = 8'd0;
                    if (row_q == nrows_q - 8'd1) begin
                        row_d   = 8'd0;
                        state_d = StIdle;
                    end else begin
                        row_d = row_q + 8'd1;
                    end
                end else begin
                    col_d = col_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy = (state_q != StIdle);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            nrows_q  <= 8'd0;
            ncols_q  <= 8'd0;
            kernel_q <= 72'd0;
            shift_q  <= 4'd0;
            row_q    <= 8'd0;
            col_q    <= 8'd0;
            tr_q     <= 2'd0;
            tc_q     <= 2'd0;
            acc_q    <= '0;
            pend_q   <= 1'b0;
            coef_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            nrows_q  <= nrows_d;
            ncols_q  <= ncols_d;
            kernel_q <= kernel_d;
            shift_q  <= shift_d;
            row_q    <= row_d;
            col_q    <= col_d;
            tr_q     <= tr_d;
            tc_q     <= tc_d;
            acc_q    <= acc_d;
            pend_q   <= pend_d;
            coef_q   <= coef_d;
        end
    end

endmodule
